// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
//   Shared definitions for the branch resolve unit and its history table:
//   RV32I branch funct3 encodings, the 2-bit saturating counter type, the
//   counter reset value and the saturating counter step function.
// -----------------------------------------------------------------------------
package branch_pkg;

  // Branch funct3 encodings. 3'b010 and 3'b011 are unused by RV32I branches.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Bimodal predictor counter: bit 1 is the predicted direction.
  typedef logic [1:0] bht_ctr_t;

  // Weakly not-taken.
  localparam bht_ctr_t BHT_RESET = 2'b01;

  // One saturating training step towards the resolved direction.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// -----------------------------------------------------------------------------
// branch_bht
//   Bimodal branch history table: ENTRIES 2-bit saturating counters.
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset; all counters -> BHT_RESET
//     rd_idx     in   read index (fetch lookup)
//     rd_taken   out  predicted direction of rd_idx (combinational)
//     upd_en     in   train one counter at this edge
//     upd_idx    in   counter to train
//     upd_taken  in   resolved direction; +1 when taken, -1 otherwise
//
//   The read port sees the pre-edge array contents, so an update to the same
//   index becomes visible on the read port only in the following cycle.
// -----------------------------------------------------------------------------
module branch_bht
  import branch_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  bht_ctr_t ctr_q [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= BHT_RESET;
      end
    end else if (upd_en) begin
      ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
    end
  end

  assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//   Registered RV32I conditional branch resolver. A branch presented with en
//   is compared, its redirect PC computed and its misprediction flagged; the
//   result appears one cycle later. Retiring results train a bimodal history
//   table that fetch reads through lookup_pc / lookup_taken.
//
//   Ports
//     clk           in   clock, rising edge
//     rst           in   synchronous active-high reset
//     en            in   valid branch presented this cycle
//     stall         in   downstream not accepting; hold the result register
//     flush         in   kill the branch that would be captured this edge
//     fun3          in   branch funct3
//     A, B          in   rs1 / rs2 values
//     pc            in   branch PC
//     imm           in   sign-extended B-type offset
//     pred_taken    in   direction fetch assumed for this branch
//     lookup_pc     in   fetch PC for the history table read
//     lookup_taken  out  history table prediction for lookup_pc (combinational)
//     res_valid     out  resolved result valid
//     res           out  branch taken
//     mispredict    out  res differs from the registered pred_taken
//     redirect_pc   out  correct next PC (pc+imm if taken, else pc+4)
//     illegal       out  fun3 is not a branch encoding
// -----------------------------------------------------------------------------
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 16,
  localparam int unsigned IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            stall,
  input  logic            flush,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic            res_valid,
  output logic            res,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal
);

  // ---------------------------------------------------------------------------
  // Compare and target computation on the issuing branch
  // ---------------------------------------------------------------------------
  logic            taken_c;
  logic            illegal_c;
  logic [XLEN-1:0] target_c;

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (fun3)
      F3_BEQ:  taken_c = (A == B);
      F3_BNE:  taken_c = (A != B);
      F3_BLT:  taken_c = ($signed(A) <  $signed(B));
      F3_BGE:  taken_c = ($signed(A) >= $signed(B));
      F3_BLTU: taken_c = (A <  B);
      F3_BGEU: taken_c = (A >= B);
      default: illegal_c = 1'b1;
    endcase
  end

  // Modulo-2^XLEN adds; carry out is intentionally dropped.
  assign target_c = taken_c ? (pc + imm) : (pc + XLEN'(4));

  // ---------------------------------------------------------------------------
  // Stage register
  // ---------------------------------------------------------------------------
  logic             valid_q, valid_d;
  logic             res_q, res_d;
  logic             mis_q, mis_d;
  logic             ill_q, ill_d;
  logic [XLEN-1:0]  rpc_q, rpc_d;
  // Only the history-table index of the branch PC is needed at retirement.
  logic [IDX_W-1:0] idx_q, idx_d;

  // Priority below reset: flush, then stall (hold), then load. Flush wins over
  // stall so a held result is dropped when both are asserted.
  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    mis_d   = mis_q;
    ill_d   = ill_q;
    rpc_d   = rpc_q;
    idx_d   = idx_q;
    if (flush) begin
      valid_d = 1'b0;
      res_d   = 1'b0;
      mis_d   = 1'b0;
      ill_d   = 1'b0;
      rpc_d   = '0;
      idx_d   = '0;
    end else if (!stall) begin
      if (en) begin
        valid_d = 1'b1;
        res_d   = taken_c;
        mis_d   = (taken_c != pred_taken);
        ill_d   = illegal_c;
        rpc_d   = target_c;
        idx_d   = pc[IDX_W+1:2];
      end else begin
        // Bubble: keeps res/mispredict/illegal low while res_valid is low.
        valid_d = 1'b0;
        res_d   = 1'b0;
        mis_d   = 1'b0;
        ill_d   = 1'b0;
        rpc_d   = '0;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      rpc_q   <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      rpc_q   <= rpc_d;
      idx_q   <= idx_d;
    end
  end

  assign res_valid   = valid_q;
  assign res         = res_q;
  assign mispredict  = mis_q;
  assign illegal     = ill_q;
  assign redirect_pc = rpc_q;

  // ---------------------------------------------------------------------------
  // Retirement and history table
  // ---------------------------------------------------------------------------
  // A result retires on the first edge where it is valid and not stalled;
  // a stalled result only retires once, on its release edge. A concurrent
  // flush does not stop the retiring result from training.
  logic retire;
  logic bht_upd;

  assign retire  = valid_q && !stall;
  assign bht_upd = retire && !ill_q && !rst;

  branch_bht #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (lookup_pc[IDX_W+1:2]),
    .rd_taken  (lookup_taken),
    .upd_en    (bht_upd),
    .upd_idx   (idx_q),
    .upd_taken (res_q)
  );

  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Directed and randomised stimulus against a behavioural model of the
//   branch resolve unit and its history table.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, en, stall, flush, pred_taken;
  logic [2:0]  fun3;
  logic [31:0] A, B, pc, imm, lookup_pc;
  logic        lookup_taken, res_valid, res, mispredict, illegal;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .XLEN        (32),
    .BHT_ENTRIES (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .stall        (stall),
    .flush        (flush),
    .fun3         (fun3),
    .A            (A),
    .B            (B),
    .pc           (pc),
    .imm          (imm),
    .pred_taken   (pred_taken),
    .lookup_pc    (lookup_pc),
    .lookup_taken (lookup_taken),
    .res_valid    (res_valid),
    .res          (res),
    .mispredict   (mispredict),
    .redirect_pc  (redirect_pc),
    .illegal      (illegal)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: counters as plain integers 0..3, result as plain fields.
  int          ctr [N];
  logic        m_valid = 1'b0;
  logic        m_res = 1'b0;
  logic        m_mis = 1'b0;
  logic        m_ill = 1'b0;
  logic [31:0] m_rpc = '0;
  int          m_idx = 0;

  function automatic logic model_taken(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] p);
    return int'((p >> 2) % N);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic r, input logic e, input logic s, input logic f,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] im, input logic pt,
                      input logic [31:0] lpc);
    logic t;
    rst = r; en = e; stall = s; flush = f; fun3 = f3;
    A = a; B = b; pc = p; imm = im; pred_taken = pt; lookup_pc = lpc;

    if (!r && m_valid && !s && !m_ill) begin
      if (m_res) ctr[m_idx] = (ctr[m_idx] < 3) ? ctr[m_idx] + 1 : 3;
      else       ctr[m_idx] = (ctr[m_idx] > 0) ? ctr[m_idx] - 1 : 0;
    end
    if (r) begin
      foreach (ctr[i]) ctr[i] = 1;
      m_valid = 0; m_res = 0; m_mis = 0; m_ill = 0; m_rpc = '0; m_idx = 0;
    end else if (f) begin
      m_valid = 0; m_res = 0; m_mis = 0; m_ill = 0; m_rpc = '0; m_idx = 0;
    end else if (!s) begin
      if (e) begin
        t       = model_taken(f3, a, b);
        m_valid = 1;
        m_ill   = (f3 == 3'd2) || (f3 == 3'd3);
        m_res   = t;
        m_mis   = (t != pt);
        m_rpc   = t ? p + im : p + 32'd4;
        m_idx   = idx_of(p);
      end else begin
        m_valid = 0; m_res = 0; m_mis = 0; m_ill = 0; m_rpc = '0; m_idx = 0;
      end
    end

    @(posedge clk);
    #1;
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
    chk("res", {31'd0, res}, {31'd0, m_res});
    chk("mispredict", {31'd0, mispredict}, {31'd0, m_mis});
    chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
    if (m_valid) chk("redirect_pc", redirect_pc, m_rpc);
    chk("lookup_taken", {31'd0, lookup_taken}, {31'd0, ctr[idx_of(lpc)] >= 2});
  endtask

  task automatic bubble(input logic [31:0] lpc);
    step(0, 0, 0, 0, 3'd0, '0, '0, '0, '0, 0, lpc);
  endtask

  initial begin
    logic [31:0] pcs [8];
    logic [31:0] ra, rb, rp, rl;
    foreach (ctr[i]) ctr[i] = 1;
    pcs = '{32'h40, 32'h44, 32'h80, 32'h84, 32'h100, 32'h3C, 32'hFFFFFFFC, 32'h1234};

    // Reset
    step(1, 1, 1, 1, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1, 32'h40);
    step(1, 0, 0, 0, 3'd0, '0, '0, '0, '0, 0, 32'h40);
    chk("rst_redirect", redirect_pc, 32'h0);

    // beq taken with wrong prediction
    step(0, 1, 0, 0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 0, 32'h100);
    chk("tp1_valid", {31'd0, res_valid}, 32'd1);
    chk("tp1_res", {31'd0, res}, 32'd1);
    chk("tp1_mis", {31'd0, mispredict}, 32'd1);
    chk("tp1_rpc", redirect_pc, 32'h120);

    // Signed vs unsigned compares
    step(0, 1, 0, 0, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 1, 32'h200);
    chk("blt_res", {31'd0, res}, 32'd1);
    step(0, 1, 0, 0, 3'd6, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 1, 32'h200);
    chk("bltu_res", {31'd0, res}, 32'd0);
    chk("bltu_rpc", redirect_pc, 32'h204);
    step(0, 1, 0, 0, 3'd5, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 0, 32'h200);
    chk("bge_res", {31'd0, res}, 32'd0);
    step(0, 1, 0, 0, 3'd7, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 0, 32'h200);
    chk("bgeu_res", {31'd0, res}, 32'd1);

    // Training at pc 0x40: three taken, four not-taken
    step(1, 0, 0, 0, 3'd0, '0, '0, '0, '0, 0, 32'h40);
    step(0, 1, 0, 0, 3'd0, 32'd7, 32'd7, 32'h40, 32'h8, 1, 32'h40);
    chk("bht_after_reset", {31'd0, lookup_taken}, 32'd0);
    step(0, 1, 0, 0, 3'd0, 32'd7, 32'd7, 32'h40, 32'h8, 1, 32'h40);
    chk("bht_first_update", {31'd0, lookup_taken}, 32'd1);
    step(0, 1, 0, 0, 3'd0, 32'd7, 32'd7, 32'h40, 32'h8, 1, 32'h40);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 3'd1, 32'd7, 32'd7, 32'h40, 32'h8, 1, 32'h40);
      if (i == 2) chk("bht_second_nt", {31'd0, lookup_taken}, 32'd0);
    end
    bubble(32'h40);

    // Stall holds result; single update on release
    step(0, 1, 0, 0, 3'd0, 32'd1, 32'd1, 32'h84, 32'h40, 1, 32'h84);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 3'd1, 32'd1, 32'd1, 32'h84, 32'h40, 1, 32'h84);
      chk("stall_rpc", redirect_pc, 32'hC4);
    end
    chk("stall_no_update", {31'd0, lookup_taken}, 32'd0);
    bubble(32'h84);
    chk("stall_release_update", {31'd0, lookup_taken}, 32'd1);
    bubble(32'h84);
    chk("stall_single_update", {31'd0, lookup_taken}, 32'd1);

    // Flush in capture cycle, then stall&&flush on a held result
    step(0, 1, 0, 1, 3'd0, 32'd2, 32'd2, 32'h88, 32'h4, 1, 32'h88);
    chk("flush_valid", {31'd0, res_valid}, 32'd0);
    bubble(32'h88);
    step(0, 1, 0, 0, 3'd0, 32'd2, 32'd2, 32'h88, 32'h4, 1, 32'h88);
    step(0, 0, 1, 1, 3'd0, '0, '0, '0, '0, 0, 32'h88);
    bubble(32'h88);
    chk("flush_no_update", {31'd0, lookup_taken}, 32'd0);

    // Illegal funct3, then PC wrap
    step(0, 1, 0, 0, 3'd3, 32'd9, 32'd9, 32'h8C, 32'h100, 1, 32'h8C);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_rpc", redirect_pc, 32'h90);
    bubble(32'h8C);
    step(0, 1, 0, 0, 3'd1, 32'd3, 32'd3, 32'hFFFFFFFC, 32'h40, 0, 32'hFFFFFFFC);
    chk("wrap_rpc", redirect_pc, 32'h0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? ra : (($urandom_range(0, 1) == 0) ? $urandom()
                                              : ra + $urandom_range(0, 2) - 1);
      rp = pcs[$urandom_range(0, 7)];
      rl = pcs[$urandom_range(0, 7)];
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           3'($urandom_range(0, 7)), ra, rb, rp, $urandom(),
           1'($urandom_range(0, 1)), rl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
